// File: rtl/btn_debounce.sv
// Per-channel button debouncer: 2-flop synchronizer, shared prescaler tick,
// four-state qualification FSM and registered level / rise / fall outputs.
module btn_debounce #(
   parameter int unsigned W         = 2,
   parameter int unsigned TICK_BITS = 19,
   parameter int unsigned CONFIRM   = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] btn_in,
   output logic [W-1:0] db_level,
   output logic [W-1:0] db_rise,
   output logic [W-1:0] db_fall
);

   localparam int unsigned CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM - 1);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_e;

   logic [W-1:0]         sync1_q, sync1_d;
   logic [W-1:0]         sync2_q, sync2_d;
   logic [TICK_BITS-1:0] presc_q, presc_d;
   state_e               state_q [W];
   state_e               state_d [W];
   logic [CNT_W-1:0]     cnt_q   [W];
   logic [CNT_W-1:0]     cnt_d   [W];
   logic [W-1:0]         db_level_q, db_level_d;
   logic [W-1:0]         db_rise_q, db_rise_d;
   logic [W-1:0]         db_fall_q, db_fall_d;
   logic                 m_tick;

   assign m_tick   = &presc_q;
   assign db_level = db_level_q;
   assign db_rise  = db_rise_q;
   assign db_fall  = db_fall_q;

   // State register: synchronizer, prescaler, FSMs and output flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         presc_q    <= '0;
         db_level_q <= '0;
         db_rise_q  <= '0;
         db_fall_q  <= '0;
         for (int unsigned i = 0; i < W; i++) begin
            state_q[i] <= ZERO;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         presc_q    <= presc_d;
         db_level_q <= db_level_d;
         db_rise_q  <= db_rise_d;
         db_fall_q  <= db_fall_d;
         for (int unsigned i = 0; i < W; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Next-state logic; an input change always beats a coincident tick.
   always_comb begin
      sync1_d = btn_in;
      sync2_d = sync1_q;
      presc_d = presc_q + TICK_BITS'(1);
      for (int unsigned i = 0; i < W; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ZERO: begin
               if (sync2_q[i]) begin
                  state_d[i] = WAIT1;
                  cnt_d[i]   = '0;
               end
            end
            WAIT1: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ZERO;
               end else if (m_tick) begin
                  if (cnt_q[i] == CNT_LAST) state_d[i] = ONE;
                  else                      cnt_d[i]   = cnt_q[i] + CNT_W'(1);
               end
            end
            ONE: begin
               if (!sync2_q[i]) begin
                  state_d[i] = WAIT0;
                  cnt_d[i]   = '0;
               end
            end
            WAIT0: begin
               if (sync2_q[i]) begin
                  state_d[i] = ONE;
               end else if (m_tick) begin
                  if (cnt_q[i] == CNT_LAST) state_d[i] = ZERO;
                  else                      cnt_d[i]   = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = ZERO;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Output logic: level follows the upcoming state so it lands with the state change.
   always_comb begin
      db_level_d = '0;
      for (int unsigned i = 0; i < W; i++) begin
         db_level_d[i] = (state_d[i] == ONE) || (state_d[i] == WAIT0);
      end
      db_rise_d = db_level_d & ~db_level_q;
      db_fall_d = ~db_level_d & db_level_q;
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with P=8, CONFIRM=3: latency windows,
// pulse counts, bounce/glitch rejection and reset during qualification.
module tb_btn_debounce;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] btn_in = 2'b11;
   logic [1:0] db_level, db_rise, db_fall;

   int checks = 0;
   int failures = 0;

   int  rise_cnt [2];
   int  fall_cnt [2];
   logic [1:0] hi_seen;
   logic       overlap_seen;

   always #5 clk = ~clk;

   btn_debounce #(.W(2), .TICK_BITS(3), .CONFIRM(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_in),
      .db_level (db_level),
      .db_rise  (db_rise),
      .db_fall  (db_fall)
   );

   // Pulse / level monitor sampled on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (db_rise[i] === 1'b1) rise_cnt[i] = rise_cnt[i] + 1;
         if (db_fall[i] === 1'b1) fall_cnt[i] = fall_cnt[i] + 1;
         if (db_level[i] === 1'b1) hi_seen[i] = 1'b1;
      end
      if ((db_rise & db_fall) !== 2'b00) overlap_seen = 1'b1;
   end

   task automatic clear_mon();
      for (int i = 0; i < 2; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
      end
      hi_seen      = 2'b00;
      overlap_seen = 1'b0;
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns cycles from the last input drive until db_level[ch]==val, 0 if never.
   task automatic wait_level(input int ch, input logic val, input int maxc, output int lat);
      lat = 0;
      for (int n = 1; n <= maxc + 1; n++) begin
         @(negedge clk);
         if (db_level[ch] === val) begin
            lat = n - 1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int lat;
      clear_mon();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({db_level, db_rise, db_fall} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs cycle=%0d got=%b required=000000", k, {db_level, db_rise, db_fall});
         end
      end
      reset = 1'b0;
      wait_level(0, 1'b1, 40, lat);
      checks++;
      if (lat < 19 || lat > 27) begin
         failures++;
         $display("FAIL reset_requal_latency got=%0d required=19..27", lat);
      end
      step(5);
      checks++;
      if (db_level !== 2'b11) begin
         failures++;
         $display("FAIL reset_requal_level got=%b required=11", db_level);
      end
      checks++;
      if (rise_cnt[0] != 1 || rise_cnt[1] != 1 || fall_cnt[0] != 0 || fall_cnt[1] != 0) begin
         failures++;
         $display("FAIL reset_requal_pulses rise=%0d/%0d fall=%0d/%0d required=1/1 0/0",
                  rise_cnt[0], rise_cnt[1], fall_cnt[0], fall_cnt[1]);
      end
      // Return both channels to idle for the following tests.
      btn_in = 2'b00;
      step(40);
      checks++;
      if (db_level !== 2'b00) begin
         failures++;
         $display("FAIL idle_level got=%b required=00", db_level);
      end
   endtask

   task automatic test_clean_press();
      int lat;
      clear_mon();
      btn_in[0] = 1'b1;
      wait_level(0, 1'b1, 40, lat);
      checks++;
      if (lat < 19 || lat > 27) begin
         failures++;
         $display("FAIL press_latency got=%0d required=19..27", lat);
      end
      step(30);
      checks++;
      if (rise_cnt[0] != 1 || fall_cnt[0] != 0) begin
         failures++;
         $display("FAIL press_pulses rise=%0d fall=%0d required=1 0", rise_cnt[0], fall_cnt[0]);
      end
      checks++;
      if (db_level[1] !== 1'b0 || hi_seen[1] !== 1'b0 || rise_cnt[1] != 0) begin
         failures++;
         $display("FAIL press_other_channel level=%b rises=%0d required=0 0", db_level[1], rise_cnt[1]);
      end
   endtask

   task automatic test_release();
      int lat;
      clear_mon();
      btn_in[0] = 1'b0;
      step(10);
      checks++;
      if (db_level[0] !== 1'b1) begin
         failures++;
         $display("FAIL release_early_level got=%b required=1", db_level[0]);
      end
      btn_in[0] = 1'b1;
      step(1);
      btn_in[0] = 1'b0;
      step(12);
      checks++;
      if (db_level[0] !== 1'b1 || fall_cnt[0] != 0) begin
         failures++;
         $display("FAIL release_bounce_hold level=%b falls=%0d required=1 0", db_level[0], fall_cnt[0]);
      end
      wait_level(0, 1'b0, 40, lat);
      lat = lat + 13;
      checks++;
      if (lat < 19 || lat > 27) begin
         failures++;
         $display("FAIL release_latency got=%0d required=19..27", lat);
      end
      step(20);
      checks++;
      if (fall_cnt[0] != 1 || rise_cnt[0] != 0) begin
         failures++;
         $display("FAIL release_pulses fall=%0d rise=%0d required=1 0", fall_cnt[0], rise_cnt[0]);
      end
   endtask

   task automatic test_bounce();
      int lat;
      clear_mon();
      for (int i = 0; i < 40; i++) begin
         btn_in[0] = ((i / 3) % 2) == 0;
         step(1);
      end
      checks++;
      if (hi_seen[0] !== 1'b0 || rise_cnt[0] != 0 || fall_cnt[0] != 0) begin
         failures++;
         $display("FAIL bounce_quiet hi=%b rise=%0d fall=%0d required=0 0 0", hi_seen[0], rise_cnt[0], fall_cnt[0]);
      end
      btn_in[0] = 1'b1;
      wait_level(0, 1'b1, 40, lat);
      checks++;
      if (lat < 19 || lat > 27) begin
         failures++;
         $display("FAIL bounce_settle_latency got=%0d required=19..27", lat);
      end
      step(20);
      checks++;
      if (rise_cnt[0] != 1 || fall_cnt[0] != 0) begin
         failures++;
         $display("FAIL bounce_pulses rise=%0d fall=%0d required=1 0", rise_cnt[0], fall_cnt[0]);
      end
   endtask

   task automatic test_glitch();
      clear_mon();
      btn_in[1] = 1'b1;
      step(5);
      btn_in[1] = 1'b0;
      step(40);
      checks++;
      if (hi_seen[1] !== 1'b0 || rise_cnt[1] != 0 || fall_cnt[1] != 0) begin
         failures++;
         $display("FAIL glitch_rejected hi=%b rise=%0d fall=%0d required=0 0 0", hi_seen[1], rise_cnt[1], fall_cnt[1]);
      end
      checks++;
      if (db_level[0] !== 1'b1 || rise_cnt[0] != 0 || fall_cnt[0] != 0) begin
         failures++;
         $display("FAIL glitch_other_channel level=%b required=1", db_level[0]);
      end
   endtask

   task automatic test_reset_mid_qual();
      int lat;
      btn_in[0] = 1'b0;
      wait_level(0, 1'b0, 40, lat);
      checks++;
      if (lat == 0) begin
         failures++;
         $display("FAIL midreset_prep_release got=%b required=0", db_level[0]);
      end
      step(5);
      clear_mon();
      btn_in[0] = 1'b1;
      step(10);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      btn_in[0] = 1'b0;
      step(40);
      checks++;
      if (hi_seen[0] !== 1'b0 || rise_cnt[0] != 0 || fall_cnt[0] != 0) begin
         failures++;
         $display("FAIL midreset_no_output hi=%b rise=%0d fall=%0d required=0 0 0", hi_seen[0], rise_cnt[0], fall_cnt[0]);
      end
   endtask

   task automatic test_overlap();
      checks++;
      if (overlap_seen !== 1'b0) begin
         failures++;
         $display("FAIL rise_fall_overlap got=%b required=0", overlap_seen);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_glitch();
      test_overlap();
      test_reset_mid_qual();
      test_overlap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
